run_ctrl: RTL and testbench
===========================

Name: run_ctrl

Overview:
- Host-side run controller: the initiator for the processor's start/halt handshake and the external end of its data-memory port.
- Preloads data memory from an input stream, then holds `start` high to initialise the core.
- Releases the core and counts cycles until `halt` is seen or a timeout expires.
- Streams a data-memory window back out.
- Sits beside the processor top level. A mux ahead of data_mem, selected by `mem_own`, gives this block the memory port outside RUN.

Parameters:
- AW, 8: data-memory address width.
- DW, 8: data word width.
- START_CYCLES, 2: cycles `dut_start` is held high after LOAD, before release; must be ≥1.
- TIMEOUT, 16'hFFFF: RUN cycle limit before abort.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- go  in  1  begin a run; sampled only in IDLE or DONE.
- load_base  in  AW  first preload address.
- load_len  in  AW+1  words to preload, 0..2^AW.
- dump_base  in  AW  first dump address.
- dump_len  in  AW+1  words to dump, 0..2^AW.
- in_valid  in  1  preload word valid.
- in_ready  out  1  preload word accepted when in_valid & in_ready.
- in_data  in  DW  preload word.
- out_valid  out  1  dump word valid.
- out_ready  in  1  dump consumer ready.
- out_data  out  DW  dump word.
- mem_own  out  1  1 = this block drives the data-memory port.
- mem_addr  out  AW  data-memory address.
- mem_wr_en  out  1  data-memory write strobe.
- mem_wr_data  out  DW  data-memory write data.
- mem_rd_en  out  1  data-memory read enable.
- mem_rd_data  in  DW  data-memory read data; combinational read of mem_addr.
- dut_start  out  1  processor init, active high.
- dut_halt  in  1  processor done flag.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next go.
- timed_out  out  1  last run hit TIMEOUT.
- cycles  out  16  RUN cycles of last run, saturating.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, dut_start=1, cycles=0, idx=0.
  - busy=done=timed_out=0; mem_own=mem_wr_en=mem_rd_en=0; in_ready=out_valid=0.
  - Takes effect immediately, including mid-run. The core stays parked while dut_start=1.
- Registered state: state, idx (AW+1), start counter, cycles, flags, latched bases/lengths.
- IDLE/DONE, go=1:
  - Latch base/len inputs; clear cycles, timed_out, done, idx; busy=1.
  - Next state is LOAD if load_len≠0, else START.
  - go outside IDLE/DONE is ignored.
- LOAD:
  - mem_own=1, dut_start=1, in_ready=1 (combinational).
  - mem_addr=load_base+idx[AW-1:0], wrapping mod 2^AW.
  - mem_wr_en=in_valid and mem_wr_data=in_data, same cycle.
  - Each accepted beat increments idx. The beat with idx==load_len-1 moves to START and clears idx.
- START:
  - dut_start=1, mem_own=0.
  - Count START_CYCLES cycles, then RUN.
- RUN:
  - dut_start=0, mem_own=0.
  - cycles increments every cycle, saturating at 16'hFFFF.
  - dut_halt=1 goes to DUMP, or DONE if dump_len=0.
  - If cycles==TIMEOUT-1 and dut_halt=0: timed_out<=1, same exit as a halt.
  - Halt and timeout in the same cycle: halt wins, timed_out stays 0.
- DUMP:
  - mem_own=1, mem_rd_en=1, dut_start=1 (core re-parked).
  - mem_addr=dump_base+idx, wrapping.
  - out_valid=1; out_data=mem_rd_data. Stable while out_ready=0 because the address is held.
  - Each out_valid & out_ready increments idx. The final beat goes to DONE.
- DONE:
  - done=1, busy=0, dut_start=1.
  - cycles and timed_out hold until the next go.
- Outputs are 0 whenever their state is inactive: mem_* outside LOAD/DUMP, in_ready outside LOAD, out_valid outside DUMP.

Test Plan:
- Preload: load_base=8'hFE, load_len=4, words A0..A3 with in_valid gaps → writes at addresses FE, FF, 00, 01 in order; in_ready=0 after the 4th beat; dut_start=1 for exactly 2 cycles after LOAD.
- Halt: dut_halt asserted 37 cycles after release → cycles=37, timed_out=0, done=1 after dump; dut_start returns to 1.
- Dump backpressure: dump_base=8'h10, dump_len=3, out_ready toggling 1/0 → out_data equals mem[10], mem[11], mem[12]; each word held stable while stalled; exactly 3 handshakes.
- Timeout: TIMEOUT=20, dut_halt never asserted → timed_out=1 and cycles=20 after 20 RUN cycles; dump still occurs; halt arriving on cycle 20 instead → timed_out=0.
- Zero lengths and re-run: load_len=0, dump_len=0 → IDLE→START→RUN→DONE with no mem_own pulses; go in DONE starts a fresh run with cleared flags.
- Async reset: reset_n low mid-LOAD (idx=2) and mid-DUMP → immediate IDLE, dut_start=1, all strobes 0; go ignored while busy.

Source files
------------

// File: rtl/run_ctrl_if.sv
// rtl/run_ctrl_if.sv - preload/dump streams, data-memory port and core start/halt handshake
interface run_ctrl_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          mem_own;
    logic [AW-1:0] mem_addr;
    logic          mem_wr_en;
    logic [DW-1:0] mem_wr_data;
    logic          mem_rd_en;
    logic [DW-1:0] mem_rd_data;
    logic          dut_start;
    logic          dut_halt;

    modport master (
        input  in_valid, in_data, out_ready, mem_rd_data, dut_halt,
        output in_ready, out_valid, out_data, mem_own, mem_addr,
               mem_wr_en, mem_wr_data, mem_rd_en, dut_start
    );

    modport slave (
        output in_valid, in_data, out_ready, mem_rd_data, dut_halt,
        input  in_ready, out_valid, out_data, mem_own, mem_addr,
               mem_wr_en, mem_wr_data, mem_rd_en, dut_start
    );
endinterface

// File: rtl/run_ctrl.sv
// rtl/run_ctrl.sv - host run controller: preload memory, start/run/halt the core, dump a memory window
module run_ctrl #(
    parameter int          AW           = 8,
    parameter int          DW           = 8,
    parameter int          START_CYCLES = 2,
    parameter logic [15:0] TIMEOUT      = 16'hFFFF
) (
    input  logic          CLK,
    input  logic          reset_n,
    input  logic          go,
    input  logic [AW-1:0] load_base,
    input  logic [AW:0]   load_len,
    input  logic [AW-1:0] dump_base,
    input  logic [AW:0]   dump_len,
    run_ctrl_if.master    bus,
    output logic          busy,
    output logic          done,
    output logic          timed_out,
    output logic [15:0]   cycles
);

    localparam int SW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_START, S_RUN, S_DUMP, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   idx_q;
    logic [SW-1:0] scnt_q;
    logic [AW-1:0] lbase_q, dbase_q;
    logic [AW:0]   llen_q, dlen_q;
    logic [15:0]   cycles_q;
    logic          timed_q;

    logic go_ok, load_beat, load_last, dump_beat, dump_last, start_last, run_timeout;

    assign go_ok       = go && (state_q == S_IDLE || state_q == S_DONE);
    assign load_beat   = (state_q == S_LOAD) && bus.in_valid;
    assign load_last   = load_beat && (idx_q == llen_q - (AW+1)'(1));
    assign dump_beat   = (state_q == S_DUMP) && bus.out_ready;
    assign dump_last   = dump_beat && (idx_q == dlen_q - (AW+1)'(1));
    assign start_last  = (scnt_q == SW'(START_CYCLES - 1));
    assign run_timeout = (cycles_q == TIMEOUT - 16'd1);

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (go) state_d = (load_len != '0) ? S_LOAD : S_START;
            S_LOAD:  if (load_last) state_d = S_START;
            S_START: if (start_last) state_d = S_RUN;
            S_RUN:   if (bus.dut_halt || run_timeout) state_d = (dlen_q != '0) ? S_DUMP : S_DONE;
            S_DUMP:  if (dump_last) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge reset_n) begin
        if (!reset_n) begin
            idx_q    <= '0;
            scnt_q   <= '0;
            lbase_q  <= '0;
            dbase_q  <= '0;
            llen_q   <= '0;
            dlen_q   <= '0;
            cycles_q <= '0;
            timed_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (go_ok) begin
                        lbase_q  <= load_base;
                        llen_q   <= load_len;
                        dbase_q  <= dump_base;
                        dlen_q   <= dump_len;
                        cycles_q <= '0;
                        timed_q  <= 1'b0;
                        idx_q    <= '0;
                        scnt_q   <= '0;
                    end
                end
                S_LOAD: begin
                    // idx restarts at zero so the dump pass can reuse it
                    if (load_beat) idx_q <= load_last ? '0 : idx_q + (AW+1)'(1);
                end
                S_START: scnt_q <= start_last ? '0 : scnt_q + SW'(1);
                S_RUN: begin
                    if (cycles_q != 16'hFFFF) cycles_q <= cycles_q + 16'd1;
                    // a halt in the timeout cycle counts as a clean finish
                    if (!bus.dut_halt && run_timeout) timed_q <= 1'b1;
                end
                S_DUMP: if (dump_beat) idx_q <= idx_q + (AW+1)'(1);
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.in_ready    = 1'b0;
        bus.out_valid   = 1'b0;
        bus.out_data    = '0;
        bus.mem_own     = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_data = '0;
        bus.mem_rd_en   = 1'b0;
        bus.dut_start   = 1'b1;
        case (state_q)
            S_LOAD: begin
                bus.mem_own     = 1'b1;
                bus.in_ready    = 1'b1;
                bus.mem_addr    = lbase_q + idx_q[AW-1:0];
                bus.mem_wr_en   = bus.in_valid;
                bus.mem_wr_data = bus.in_data;
            end
            S_RUN: bus.dut_start = 1'b0;
            S_DUMP: begin
                // address is held across stalls, so out_data stays stable
                bus.mem_own   = 1'b1;
                bus.mem_rd_en = 1'b1;
                bus.mem_addr  = dbase_q + idx_q[AW-1:0];
                bus.out_valid = 1'b1;
                bus.out_data  = bus.mem_rd_data;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done      = (state_q == S_DONE);
    assign timed_out = timed_q;
    assign cycles    = cycles_q;

endmodule

// File: tb/tb_run_ctrl.sv
// tb/tb_run_ctrl.sv - self-checking bench for run_ctrl
module tb_run_ctrl;
    localparam int          AW = 8;
    localparam int          DW = 8;
    localparam int          SC = 2;
    localparam logic [15:0] TO = 16'd40;

    logic        CLK       = 1'b0;
    logic        reset_n   = 1'b0;
    logic        go        = 1'b0;
    logic [7:0]  load_base = '0;
    logic [7:0]  dump_base = '0;
    logic [8:0]  load_len  = '0;
    logic [8:0]  dump_len  = '0;
    logic        busy, done, timed_out;
    logic [15:0] cycles;
    logic        init_req  = 1'b1;

    run_ctrl_if #(.AW(AW), .DW(DW)) bus();

    run_ctrl #(.AW(AW), .DW(DW), .START_CYCLES(SC), .TIMEOUT(TO)) dut (
        .CLK(CLK), .reset_n(reset_n), .go(go),
        .load_base(load_base), .load_len(load_len),
        .dump_base(dump_base), .dump_len(dump_len),
        .bus(bus),
        .busy(busy), .done(done), .timed_out(timed_out), .cycles(cycles)
    );

    always #5 CLK = ~CLK;

    logic [7:0] mem[256];
    logic [7:0] ref_mem[256];
    int         own_cnt = 0;

    assign bus.mem_rd_data = mem[bus.mem_addr];

    always @(posedge CLK) begin
        if (init_req) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
        end else if (bus.mem_own && bus.mem_wr_en) begin
            mem[bus.mem_addr] <= bus.mem_wr_data;
        end
        if (bus.mem_own) own_cnt <= own_cnt + 1;
    end

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Spec-level outcome of a RUN phase: halt on RUN cycle n (1-based) wins up to TO.
    function automatic int model_cycles(input int halt_at);
        return (halt_at >= 1 && halt_at <= int'(TO)) ? halt_at : int'(TO);
    endfunction

    typedef struct {
        logic [7:0] lb;
        logic [8:0] ll;
        logic [7:0] db;
        logic [8:0] dl;
        int         halt_at;
        int         rmode;
        int         gap;
        logic [7:0] ws;
        bit         poke;
        int         exp_c;
        bit         exp_t;
    } vec_t;

    vec_t tbl[10];

    task automatic do_run(input vec_t v);
        int loaded, sc, rc, got, budget, own0;
        bit tog;
        own0 = own_cnt;
        @(negedge CLK);
        load_base = v.lb; load_len = v.ll; dump_base = v.db; dump_len = v.dl; go = 1'b1;
        @(negedge CLK);
        go = 1'b0;
        #1;
        chk("go_busy", 32'(busy), 32'd1);
        chk("go_clear", 32'({done, timed_out, cycles}), 32'd0);

        loaded = 0; budget = 0;
        while (loaded < int'(v.ll) && budget < 3000) begin
            bus.in_valid = ($urandom_range(99) >= v.gap);
            bus.in_data  = v.ws + 8'(loaded);
            #1;
            chk("ld_ready", 32'(bus.in_ready), 32'd1);
            if (bus.in_valid) begin
                chk("ld_write", 32'({bus.mem_own, bus.mem_wr_en, bus.mem_addr, bus.mem_wr_data}),
                    32'({1'b1, 1'b1, v.lb + 8'(loaded), v.ws + 8'(loaded)}));
                ref_mem[v.lb + 8'(loaded)] = v.ws + 8'(loaded);
                loaded++;
            end
            @(negedge CLK);
            budget++;
        end
        bus.in_valid = 1'b0;
        #1;
        chk("ld_count", 32'(loaded), 32'(v.ll));
        chk("ld_after", 32'({bus.in_ready, bus.mem_own}), 32'd0);

        sc = 0;
        while (bus.dut_start && busy && sc < 50) begin
            chk("start_own", 32'(bus.mem_own), 32'd0);
            sc++;
            @(negedge CLK);
        end
        chk("start_len", 32'(sc), 32'(SC));

        rc = 0;
        while (!bus.dut_start && rc < 300) begin
            rc++;
            bus.dut_halt = (rc == v.halt_at);
            go = v.poke && (rc == 2);
            if (go) dump_base = ~v.db;
            @(negedge CLK);
            go = 1'b0;
            dump_base = v.db;
        end
        bus.dut_halt = 1'b0;
        chk("run_len", 32'(rc), 32'(v.exp_c));
        chk("cycles", 32'(cycles), 32'(v.exp_c));
        chk("timed_out", 32'(timed_out), 32'(v.exp_t));

        got = 0; budget = 0; tog = 1'b1;
        while (got < int'(v.dl) && budget < 3000) begin
            bus.out_ready = (v.rmode == 0) ? 1'b1 : (v.rmode == 1) ? tog : 1'($urandom_range(1));
            tog = !tog;
            #1;
            chk("dump_word", 32'({bus.out_valid, bus.mem_rd_en, bus.mem_wr_en, bus.dut_start, bus.mem_addr, bus.out_data}),
                32'({1'b1, 1'b1, 1'b0, 1'b1, v.db + 8'(got), ref_mem[v.db + 8'(got)]}));
            if (bus.out_ready) got++;
            @(negedge CLK);
            budget++;
        end
        bus.out_ready = 1'b0;
        #1;
        chk("dump_count", 32'(got), 32'(v.dl));
        chk("end_state", 32'({done, busy, bus.dut_start, bus.mem_own, bus.out_valid, bus.in_ready}), 32'b101000);
        chk("end_hold", 32'({timed_out, cycles}), 32'({v.exp_t, 16'(v.exp_c)}));
        if (v.ll == 0 && v.dl == 0) chk("zero_own", 32'(own_cnt - own0), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, 32'({bus.in_ready, bus.mem_own, bus.mem_wr_en, bus.mem_rd_en, bus.out_valid,
                       busy, done, timed_out, bus.dut_start, cycles}), 32'({9'b000000001, 16'd0}));
    endtask

    initial begin
        vec_t rv;
        int   k;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0; bus.dut_halt = 1'b0;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;

        tbl[0] = '{8'hFE, 9'd4,   8'hFE, 9'd4,   37, 2, 40, 8'hA0, 1'b0, 37, 1'b0};
        tbl[1] = '{8'h10, 9'd3,   8'h10, 9'd3,   5,  1, 0,  8'h55, 1'b0, 5,  1'b0};
        tbl[2] = '{8'h20, 9'd2,   8'h20, 9'd2,   0,  0, 0,  8'h11, 1'b0, 40, 1'b1};
        tbl[3] = '{8'h20, 9'd2,   8'h21, 9'd1,   40, 0, 0,  8'h22, 1'b0, 40, 1'b0};
        tbl[4] = '{8'h40, 9'd1,   8'h40, 9'd1,   6,  0, 0,  8'h33, 1'b1, 6,  1'b0};
        tbl[5] = '{8'h00, 9'd0,   8'h00, 9'd0,   7,  0, 0,  8'h00, 1'b0, 7,  1'b0};
        tbl[6] = '{8'h00, 9'd0,   8'h00, 9'd0,   0,  0, 0,  8'h00, 1'b0, 40, 1'b1};
        tbl[7] = '{8'h00, 9'd0,   8'h00, 9'd0,   3,  0, 0,  8'h00, 1'b0, 3,  1'b0};
        tbl[8] = '{8'h80, 9'd256, 8'h80, 9'd256, 2,  2, 20, 8'h07, 1'b0, 2,  1'b0};
        tbl[9] = '{8'hF0, 9'd32,  8'h00, 9'd16,  41, 2, 30, 8'hC3, 1'b0, 40, 1'b1};

        repeat (3) @(negedge CLK);
        init_req = 1'b0;
        #1;
        chk_reset_outputs("reset_init");
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) do_run(tbl[i]);

        // Async reset in the middle of LOAD with two beats already accepted.
        @(negedge CLK);
        load_base = 8'h30; load_len = 9'd4; dump_len = 9'd0; go = 1'b1;
        @(negedge CLK);
        go = 1'b0;
        for (int b = 0; b < 2; b++) begin
            bus.in_valid = 1'b1; bus.in_data = 8'hC0 + 8'(b);
            ref_mem[8'h30 + 8'(b)] = 8'hC0 + 8'(b);
            @(negedge CLK);
        end
        bus.in_data = 8'hC2;
        #1;
        chk("rstA_pre", 32'({bus.in_ready, bus.mem_wr_en, bus.mem_addr}), 32'({2'b11, 8'h32}));
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rstA_outputs");
        bus.in_valid = 1'b0;
        @(negedge CLK);
        reset_n = 1'b1;

        // Async reset in the middle of DUMP after one handshake.
        @(negedge CLK);
        load_len = 9'd0; dump_base = 8'h30; dump_len = 9'd4; go = 1'b1;
        @(negedge CLK);
        go = 1'b0;
        k = 0;
        while (bus.dut_start && k < 20) begin @(negedge CLK); k++; end
        chk("rstB_run", 32'(bus.dut_start), 32'd0);
        bus.dut_halt = 1'b1;
        @(negedge CLK);
        bus.dut_halt = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge CLK);
        bus.out_ready = 1'b0;
        #1;
        chk("rstB_pre", 32'({bus.out_valid, bus.mem_addr, bus.out_data}), 32'({1'b1, 8'h31, ref_mem[8'h31]}));
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("rstB_outputs");
        @(negedge CLK);
        reset_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            rv.lb      = 8'($urandom);
            rv.ll      = 9'($urandom_range(20));
            rv.db      = 8'($urandom);
            rv.dl      = 9'($urandom_range(20));
            rv.halt_at = int'($urandom_range(50));
            rv.rmode   = 2;
            rv.gap     = int'($urandom_range(60));
            rv.ws      = 8'($urandom);
            rv.poke    = 1'($urandom_range(1));
            if (rv.poke && rv.halt_at == 1) rv.halt_at = 5;
            rv.exp_c   = model_cycles(rv.halt_at);
            rv.exp_t   = !(rv.halt_at >= 1 && rv.halt_at <= int'(TO));
            do_run(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
